pipeline_hazard_ctrl: RTL and testbench

//  Stall/flush scheduler for the 5-stage pipeline, used alongside the forwarding unit.
//  - Detects RAW hazards between the ID-stage sources and the EXE/MEM destinations.
//  - Sequences multi-cycle data-memory accesses with a wait-state FSM.
//  - Converts taken branches into IF/ID flushes and ID/EXE bubbles.
//  - Drives the freeze, flush and bubble controls of every pipeline register.
//  - Keeps saturating performance counters.

---
 rtl/pipeline_hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: RAW hazard detection, data-memory wait states,
// branch flushes and saturating perf counters. Optional macro FORWARDING_EN limits stalls to load-use.
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_WAIT_CYCLES = 4,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       id_src1,
    input  logic [3:0]       id_src2,
    input  logic             id_use_src1,
    input  logic             id_two_src,
    input  logic [3:0]       exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [3:0]       mem_dest,
    input  logic             mem_wb_en,
    input  logic             mem_req,
    input  logic             branch_taken,
    output logic             freeze_pc,
    output logic             freeze_if_id,
    output logic             flush_if_id,
    output logic             bubble_id_ex,
    output logic             freeze_all,
    output logic             busy_state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [7:0]       flush_count
);

    localparam int unsigned WAIT_W = 8;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MEM_WAIT_CYCLES - 1);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t             r_state;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic [CNT_W-1:0]   r_stall_cycles;
    logic [7:0]         r_flush_count;

    logic w_exe_match;
    logic w_hazard;
    logic w_freeze_all;
    logic w_freeze_pc;
    logic w_freeze_if_id;
    logic w_flush_if_id;
    logic w_bubble_id_ex;

    // Source-vs-destination compare; only operands the ID instruction actually reads count.
    assign w_exe_match = (id_use_src1 && (id_src1 == exe_dest)) ||
                         (id_two_src  && (id_src2 == exe_dest));

`ifdef FORWARDING_EN
    assign w_hazard = exe_wb_en && exe_mem_r_en && w_exe_match;
`else
    logic w_mem_match;
    assign w_mem_match = (id_use_src1 && (id_src1 == mem_dest)) ||
                         (id_two_src  && (id_src2 == mem_dest));
    assign w_hazard = (exe_wb_en && w_exe_match) || (mem_wb_en && w_mem_match);
`endif

    // Freeze is raised in the request cycle itself, then held while the wait counter is nonzero.
    always_comb begin
        w_freeze_all   = 1'b0;
        w_freeze_pc    = 1'b0;
        w_freeze_if_id = 1'b0;
        w_flush_if_id  = 1'b0;
        w_bubble_id_ex = 1'b0;
        if (r_state == RUN) begin
            w_freeze_all = mem_req;
        end else begin
            w_freeze_all = (r_wait_cnt != '0);
        end
        if (w_freeze_all) begin
            w_freeze_pc    = 1'b1;
            w_freeze_if_id = 1'b1;
        end else if (branch_taken) begin
            w_flush_if_id  = 1'b1;
            w_bubble_id_ex = 1'b1;
        end else if (w_hazard) begin
            w_freeze_pc    = 1'b1;
            w_freeze_if_id = 1'b1;
            w_bubble_id_ex = 1'b1;
        end
    end

    // Wait-state FSM; mem_req is not sampled in MEM_WAIT so one access triggers one wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (mem_req) begin
                        r_state    <= MEM_WAIT;
                        r_wait_cnt <= WAIT_LOAD;
                    end
                end
                MEM_WAIT: begin
                    if (r_wait_cnt != '0) begin
                        r_wait_cnt <= r_wait_cnt - WAIT_W'(1);
                    end else begin
                        r_state <= RUN;
                    end
                end
                default: begin
                    r_state    <= RUN;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_freeze_pc && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
            if (w_flush_if_id && (r_flush_count != 8'hFF)) begin
                r_flush_count <= r_flush_count + 8'(1);
            end
        end
    end

    assign freeze_pc    = w_freeze_pc;
    assign freeze_if_id = w_freeze_if_id;
    assign flush_if_id  = w_flush_if_id;
    assign bubble_id_ex = w_bubble_id_ex;
    assign freeze_all   = w_freeze_all;
    assign busy_state   = (r_state == MEM_WAIT);
    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus random traffic against a cycle-indexed
// reference model of the access windows, hazard rules and counters.
module tb_pipeline_hazard_ctrl;

    localparam int N  = 4;
    localparam int CW = 16;
    localparam int STALL_MAX = 65535;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    id_src1, id_src2, exe_dest, mem_dest;
    logic          id_use_src1, id_two_src, exe_wb_en, exe_mem_r_en;
    logic          mem_wb_en, mem_req, branch_taken;
    logic          freeze_pc, freeze_if_id, flush_if_id, bubble_id_ex, freeze_all, busy_state;
    logic [CW-1:0] stall_cycles;
    logic [7:0]    flush_count;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_WAIT_CYCLES(N), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_src1(id_src1), .id_src2(id_src2), .id_use_src1(id_use_src1), .id_two_src(id_two_src),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_req(mem_req), .branch_taken(branch_taken),
        .freeze_pc(freeze_pc), .freeze_if_id(freeze_if_id), .flush_if_id(flush_if_id),
        .bubble_id_ex(bubble_id_ex), .freeze_all(freeze_all), .busy_state(busy_state),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    int checks = 0;
    int errors = 0;
    // Model: cycle index, start cycle of the current access (-1 = none), counters.
    int cyc = 0;
    int acc_start = -1;
    int stall_m = 0;
    int flush_m = 0;
    int frz_seen = 0;
    int base;

    function automatic logic m1(input logic [3:0] d);
        return id_use_src1 && (id_src1 == d);
    endfunction

    function automatic logic m2(input logic [3:0] d);
        return id_two_src && (id_src2 == d);
    endfunction

    function automatic logic hz_model();
`ifdef FORWARDING_EN
        return exe_wb_en && exe_mem_r_en && (m1(exe_dest) || m2(exe_dest));
`else
        return (exe_wb_en && (m1(exe_dest) || m2(exe_dest))) ||
               (mem_wb_en && (m1(mem_dest) || m2(mem_dest)));
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        id_src1 = 4'd0; id_src2 = 4'd0; exe_dest = 4'd0; mem_dest = 4'd0;
        id_use_src1 = 1'b0; id_two_src = 1'b0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
        mem_wb_en = 1'b0; mem_req = 1'b0; branch_taken = 1'b0;
    endtask

    // Called at posedge+1 with inputs already driven; checks mid-cycle, advances one clock.
    task automatic step();
        logic in_wait, start, frz, hz, e_fpc, e_fl, e_bub;
        #3;
        // An access started at cycle s freezes s..s+N-1; the FSM is busy during s+1..s+N.
        in_wait = (acc_start >= 0) && (cyc > acc_start) && (cyc <= acc_start + N);
        start   = !in_wait && mem_req;
        frz     = start || (in_wait && (cyc < acc_start + N));
        hz      = hz_model();
        e_fl    = !frz && branch_taken;
        e_fpc   = frz || (!branch_taken && hz);
        e_bub   = !frz && (branch_taken || hz);
        chk("freeze_all",   32'(freeze_all),   32'(frz));
        chk("freeze_pc",    32'(freeze_pc),    32'(e_fpc));
        chk("freeze_if_id", 32'(freeze_if_id), 32'(e_fpc));
        chk("flush_if_id",  32'(flush_if_id),  32'(e_fl));
        chk("bubble_id_ex", 32'(bubble_id_ex), 32'(e_bub));
        chk("busy_state",   32'(busy_state),   32'(in_wait));
        chk("stall_cycles", 32'(stall_cycles), 32'(stall_m));
        chk("flush_count",  32'(flush_count),  32'(flush_m));
        if (frz) frz_seen++;
        @(posedge clk);
        if (start) acc_start = cyc;
        if (e_fpc && stall_m < STALL_MAX) stall_m++;
        if (e_fl && flush_m < 255) flush_m++;
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_busy",       32'(busy_state),   32'd0);
        chk("rst_stall",      32'(stall_cycles), 32'd0);
        chk("rst_flush",      32'(flush_count),  32'd0);
        chk("rst_freeze_all", 32'(freeze_all),   32'(mem_req));
        acc_start = -1;
        stall_m   = 0;
        flush_m   = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        #1;
        chk("init_busy",  32'(busy_state),   32'd0);
        chk("init_stall", 32'(stall_cycles), 32'd0);
        chk("init_flush", 32'(flush_count),  32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Memory wait: one request freezes the whole pipe for exactly N cycles.
        base = stall_m;
        frz_seen = 0;
        mem_req = 1'b1;
        step();
        mem_req = 1'b0;
        repeat (N + 2) step();
        chk("t2_frozen_cycles", 32'(frz_seen), 32'(N));
        chk("t2_stall_delta",   32'(stall_cycles - CW'(base)), 32'(N));

        // Back-to-back requests: a new wait starts only after the FSM has returned to RUN.
        mem_req = 1'b1;
        repeat (2 * N + 3) step();
        mem_req = 1'b0;
        repeat (N + 2) step();

`ifdef FORWARDING_EN
        // Load-use stalls; a plain ALU producer in EXE does not.
        exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; exe_dest = 4'd3; id_src1 = 4'd3; id_use_src1 = 1'b1;
        step();
        exe_mem_r_en = 1'b0;
        step();
`else
        // Without forwarding any pending producer in MEM stalls when the operand is read.
        mem_wb_en = 1'b1; mem_dest = 4'd5; id_src2 = 4'd5; id_two_src = 1'b1;
        step();
        id_two_src = 1'b0;
        step();
`endif
        clear_inputs();

        // Branch beats a load-use hazard.
        base = flush_m;
        exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; exe_dest = 4'd3; id_src1 = 4'd3; id_use_src1 = 1'b1;
        branch_taken = 1'b1;
        step();
        chk("t5_flush_delta", 32'(flush_count - 8'(base)), 32'd1);
        clear_inputs();
        step();

        // Branch during a memory freeze is held off until the release cycle.
        base = flush_m;
        mem_req = 1'b1; branch_taken = 1'b1;
        step();
        mem_req = 1'b0;
        repeat (N) step();
        branch_taken = 1'b0;
        step();
        chk("t6_flush_delta", 32'(flush_count - 8'(base)), 32'd1);

        // Reset in the middle of a wait clears state and counters asynchronously.
        mem_req = 1'b1;
        step();
        mem_req = 1'b0;
        step();
        step();
        chk("t1_busy_before_rst", 32'(busy_state), 32'd1);
        do_reset();
        step();

        // Random traffic over a narrow register range so matches are frequent.
        for (int i = 0; i < 400; i++) begin
            id_src1      = 4'($urandom_range(0, 3));
            id_src2      = 4'($urandom_range(0, 3));
            exe_dest     = 4'($urandom_range(0, 3));
            mem_dest     = 4'($urandom_range(0, 3));
            id_use_src1  = 1'($urandom_range(0, 1));
            id_two_src   = 1'($urandom_range(0, 1));
            exe_wb_en    = 1'($urandom_range(0, 1));
            exe_mem_r_en = 1'($urandom_range(0, 1));
            mem_wb_en    = 1'($urandom_range(0, 1));
            mem_req      = ($urandom_range(0, 5) == 0);
            branch_taken = ($urandom_range(0, 3) == 0);
            step();
        end
        clear_inputs();
        repeat (N + 2) step();

        // Flush counter saturates at 255.
        branch_taken = 1'b1;
        repeat (260) step();
        chk("flush_sat", 32'(flush_count), 32'd255);
        branch_taken = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
